// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - requester and memory bus bundle for memory_arbiter
interface memory_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          f_req;
    logic [AW-1:0] f_address;
    logic          f_done;
    logic          r_req;
    logic [AW-1:0] r_address;
    logic          r_done;
    logic          w_req;
    logic [AW-1:0] w_address;
    logic [DW-1:0] w_data;
    logic          w_done;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_enable;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;

    modport slave (
        input  f_req, f_address, r_req, r_address, w_req, w_address, w_data,
        input  mem_rdata, mem_valid,
        output f_done, r_done, w_done, rdata, err,
        output mem_enable, mem_write, mem_address, mem_wdata
    );

    modport master (
        output f_req, f_address, r_req, r_address, w_req, w_address, w_data,
        output mem_rdata, mem_valid,
        input  f_done, r_done, w_done, rdata, err,
        input  mem_enable, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - three-way arbiter onto one memory port; MEMORY_ARBITER_TIMEOUT_EN adds a BUSY abort
module memory_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic              clock,
    input logic              reset,
    memory_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OWN_F = 2'd0;
    localparam logic [1:0] OWN_R = 2'd1;
    localparam logic [1:0] OWN_W = 2'd2;

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]    state;
    logic [1:0]    owner;
    logic [1:0]    pick;
    logic [SW-1:0] starve;
    logic          any_req;
    logic          f_forced;
    logic          timed_out;
    logic          finish;

    logic          en_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          f_done_q;
    logic          r_done_q;
    logic          w_done_q;
    logic          err_q;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == IDLE) begin
            tcnt <= '0;
        end else if (state == BUSY && !timed_out) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timed_out = (state == BUSY) && (tcnt == TW'(TIMEOUT));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        any_req  = bus.f_req | bus.r_req | bus.w_req;
        f_forced = bus.f_req && (starve == SW'(STARVE_LIMIT));
        pick     = OWN_F;
        if (f_forced) begin
            pick = OWN_F;
        end else if (bus.w_req) begin
            pick = OWN_W;
        end else if (bus.r_req) begin
            pick = OWN_R;
        end
        // A real response always beats the timeout on the same cycle
        finish = (state == BUSY) && (bus.mem_valid || timed_out);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= OWN_F;
            starve   <= '0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            f_done_q <= 1'b0;
            r_done_q <= 1'b0;
            w_done_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= pick;
                        en_q  <= 1'b1;
                        wr_q  <= (pick == OWN_W);
                        case (pick)
                            OWN_W:   addr_q <= bus.w_address;
                            OWN_R:   addr_q <= bus.r_address;
                            default: addr_q <= bus.f_address;
                        endcase
                        wdata_q <= (pick == OWN_W) ? bus.w_data : '0;
                        if (pick == OWN_F) begin
                            starve <= '0;
                        end else if (bus.f_req && starve != SW'(STARVE_LIMIT)) begin
                            starve <= starve + 1'b1;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        en_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        addr_q   <= '0;
                        wdata_q  <= '0;
                        f_done_q <= (owner == OWN_F);
                        r_done_q <= (owner == OWN_R);
                        w_done_q <= (owner == OWN_W);
                        if (bus.mem_valid && owner != OWN_W) begin
                            rdata_q <= bus.mem_rdata;
                        end else begin
                            rdata_q <= '0;
                        end
                        err_q <= !bus.mem_valid;
                        state <= DONE;
                    end
                end
                DONE: begin
                    f_done_q <= 1'b0;
                    r_done_q <= 1'b0;
                    w_done_q <= 1'b0;
                    rdata_q  <= '0;
                    err_q    <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_enable  = en_q;
    assign bus.mem_write   = wr_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.f_done      = f_done_q;
    assign bus.r_done      = r_done_q;
    assign bus.w_done      = w_done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed vector bench for memory_arbiter
module tb_memory_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] WF = 2'd0;
    localparam logic [1:0] WR = 2'd1;
    localparam logic [1:0] WW = 2'd2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    memory_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    memory_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rf;
        logic        rr;
        logic        rw;
        logic [31:0] fa;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          lat;
        logic [1:0]  win;
        logic [31:0] ea;
        logic        ew;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[6];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_en"}, bus.mem_enable, 1'b0);
        chk({name, "_wr"}, bus.mem_write, 1'b0);
        chk({name, "_addr"}, bus.mem_address, 32'h0);
        chk({name, "_wdata"}, bus.mem_wdata, 32'h0);
        chk({name, "_dones"}, {bus.w_done, bus.r_done, bus.f_done}, 3'b000);
        chk({name, "_rdata"}, bus.rdata, 32'h0);
        chk({name, "_err"}, bus.err, 1'b0);
    endtask

    task automatic run_txn(input logic [1:0] win, input logic [31:0] ea, input logic ew,
                           input logic [31:0] ewd, input logic [31:0] mrd, input int lat,
                           input logic [31:0] erd, input logic drop);
        logic [2:0] onehot;
        onehot = 3'b001 << win;
        step();
        chk("grant_en", bus.mem_enable, 1'b1);
        chk("grant_wr", bus.mem_write, ew);
        chk("grant_addr", bus.mem_address, ea);
        chk("grant_wdata", bus.mem_wdata, ewd);
        for (int k = 0; k < lat; k++) begin
            step();
            chk("hold_en", bus.mem_enable, 1'b1);
            chk("hold_addr", bus.mem_address, ea);
            chk("hold_wdata", bus.mem_wdata, ewd);
            chk("hold_nodone", {bus.w_done, bus.r_done, bus.f_done}, 3'b000);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mrd;
        step();
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        chk("done_who", {bus.w_done, bus.r_done, bus.f_done}, onehot);
        chk("done_rdata", bus.rdata, erd);
        chk("done_err", bus.err, 1'b0);
        chk("done_en", bus.mem_enable, 1'b0);
        if (drop) begin
            if (win == WF) bus.f_req = 1'b0;
            if (win == WR) bus.r_req = 1'b0;
            if (win == WW) bus.w_req = 1'b0;
        end
        step();
        chk("pulse_once", {bus.w_done, bus.r_done, bus.f_done}, 3'b000);
        chk("gap_en", bus.mem_enable, 1'b0);
    endtask

    initial begin
        bus.f_req = 0; bus.f_address = '0;
        bus.r_req = 0; bus.r_address = '0;
        bus.w_req = 0; bus.w_address = '0; bus.w_data = '0;
        bus.mem_rdata = '0; bus.mem_valid = 0;

        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 3,
                  WF, 32'h100, 1'b0, 32'h0, 32'hDEADBEEF};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h20, 32'h55, 32'h12345678, 2,
                  WW, 32'h20, 1'b1, 32'h55, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'h300, 32'h200, 32'h40, 32'hA5A5, 32'h99999999, 1,
                  WW, 32'h40, 1'b1, 32'hA5A5, 32'h0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 2,
                  WR, 32'h200, 1'b0, 32'h0, 32'hCAFEF00D};
        vt[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 4,
                  WF, 32'h300, 1'b0, 32'h0, 32'h0BADF00D};
        vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0, 32'h00000011, 0,
                  WR, 32'h44, 1'b0, 32'h0, 32'h00000011};

        step();
        step();
        chk_idle_outputs("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            if (vt[i].rf) begin bus.f_req = 1'b1; bus.f_address = vt[i].fa; end
            if (vt[i].rr) begin bus.r_req = 1'b1; bus.r_address = vt[i].ra; end
            if (vt[i].rw) begin bus.w_req = 1'b1; bus.w_address = vt[i].wa; bus.w_data = vt[i].wd; end
            run_txn(vt[i].win, vt[i].ea, vt[i].ew, vt[i].ewd, vt[i].mrd, vt[i].lat,
                    vt[i].erd, 1'b1);
        end

        // Starvation: stores held continuously against a waiting fetch
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.f_req = 1'b1; bus.f_address = 32'h500;
        bus.w_req = 1'b1; bus.w_address = 32'h60; bus.w_data = 32'h77;
        for (int k = 0; k < 6; k++) begin
            if (k == 4)
                run_txn(WF, 32'h500, 1'b0, 32'h0, 32'hF00D0000 + k, 1, 32'hF00D0000 + k, 1'b0);
            else
                run_txn(WW, 32'h60, 1'b1, 32'h77, 32'h1234 + k, 1, 32'h0, 1'b0);
        end
        bus.f_req = 1'b0;
        bus.w_req = 1'b0;
        step();
        step();

        // Reset while BUSY abandons the transaction
        bus.f_req = 1'b1; bus.f_address = 32'h80;
        step();
        chk("rst_busy_en", bus.mem_enable, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.f_req = 1'b0;
        chk_idle_outputs("rst_busy");
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hFFFF;
        step();
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        chk("idle_valid_dones", {bus.w_done, bus.r_done, bus.f_done}, 3'b000);
        chk("idle_valid_rdata", bus.rdata, 32'h0);
        step();
        chk("idle_valid_dones2", {bus.w_done, bus.r_done, bus.f_done}, 3'b000);
        chk("idle_valid_en", bus.mem_enable, 1'b0);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
        bus.r_req = 1'b1; bus.r_address = 32'h90;
        step();
        chk("to_en", bus.mem_enable, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("to_wait", bus.r_done, 1'b0);
        end
        step();
        chk("to_done", bus.r_done, 1'b1);
        chk("to_err", bus.err, 1'b1);
        chk("to_rdata", bus.rdata, 32'h0);
        chk("to_en_drop", bus.mem_enable, 1'b0);
        bus.r_req = 1'b0;
        step();
        chk("to_once", bus.r_done, 1'b0);
        bus.r_req = 1'b1;
        step();
        chk("to2_en", bus.mem_enable, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("to2_wait", bus.r_done, 1'b0);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hABCD;
        step();
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        chk("to2_done", bus.r_done, 1'b1);
        chk("to2_err", bus.err, 1'b0);
        chk("to2_rdata", bus.rdata, 32'hABCD);
        bus.r_req = 1'b0;
        step();
`else
        bus.r_req = 1'b1; bus.r_address = 32'h90;
        step();
        chk("wait_en", bus.mem_enable, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("wait_nodone", bus.r_done, 1'b0);
        end
        chk("wait_still_en", bus.mem_enable, 1'b1);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'hABCD;
        step();
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        chk("wait_done", bus.r_done, 1'b1);
        chk("wait_err", bus.err, 1'b0);
        chk("wait_rdata", bus.rdata, 32'hABCD);
        bus.r_req = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
